// File: rtl/fetch_pc_unit.sv
// Purpose : fetch-stage PC owner; issues one imem request at a time and buffers {instr, pc} for ID.
// Latency : request accepted -> instruction in buffer on the edge that captures the response (>= 2 cycles/instr).
// Backpressure: a request is issued only when the one-entry buffer will be free; buffer held while !id_ready.
//
// Ports:
//   clk, reset                      - single clock, synchronous active-high reset
//   redirect_valid, redirect_pc     - PC change from the resolving stage (bits [1:0] ignored)
//   imem_req_valid/ready/addr       - instruction-memory request handshake
//   imem_rsp_valid/data             - instruction-memory response (always accepted)
//   if_valid/id_ready/if_instr/if_pc - one-entry output buffer towards ID
//   fetch_count                     - instructions handed to ID, wraps
module fetch_pc_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             redirect_valid,
    input  logic [31:0]      redirect_pc,
    output logic             imem_req_valid,
    input  logic             imem_req_ready,
    output logic [31:0]      imem_req_addr,
    input  logic             imem_rsp_valid,
    input  logic [31:0]      imem_rsp_data,
    output logic             if_valid,
    input  logic             id_ready,
    output logic [31:0]      if_instr,
    output logic [31:0]      if_pc,
    output logic [CNT_W-1:0] fetch_count
);

    typedef enum logic {
        S_REQ  = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [31:0]        r_pc;
    logic [31:0]        r_req_pc;
    logic               r_discard;
    logic               r_if_valid;
    logic [31:0]        r_if_instr;
    logic [31:0]        r_if_pc;
    logic [CNT_W-1:0]   r_fetch_count;

    logic               w_req_vld;
    logic               w_req_fire;
    logic               w_rsp_in_wait;
    logic               w_rsp_load;
    logic               w_consume;
    logic [31:0]        w_redirect_pc;
    logic               w_unused_low_bits;

    assign w_redirect_pc     = {redirect_pc[31:2], 2'b00};
    assign w_unused_low_bits = ^redirect_pc[1:0];

    // Next-state and request-valid logic.
    always_comb begin
        w_state_nxt = r_state;
        w_req_vld   = 1'b0;
        case (r_state)
            S_REQ: begin
                // Only ask when the buffer is guaranteed free by the time the
                // response can land, so a response never finds it full.
                w_req_vld = !r_if_valid || id_ready;
                if (w_req_vld && imem_req_ready) begin
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_rsp_valid) begin
                    w_state_nxt = S_REQ;
                end
            end
            default: w_state_nxt = S_REQ;
        endcase
    end

    // Reset gates the request so nothing is issued in the reset cycle.
    assign imem_req_valid = w_req_vld && !reset;
    assign w_req_fire     = imem_req_valid && imem_req_ready;
    assign w_rsp_in_wait  = (r_state == S_WAIT) && imem_rsp_valid;
    assign w_rsp_load     = w_rsp_in_wait && !r_discard && !redirect_valid;
    assign w_consume      = r_if_valid && id_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_REQ;
            r_pc          <= RESET_PC;
            r_req_pc      <= RESET_PC;
            r_discard     <= 1'b0;
            r_if_valid    <= 1'b0;
            r_if_instr    <= 32'd0;
            r_if_pc       <= 32'd0;
            r_fetch_count <= '0;
        end else begin
            r_state <= w_state_nxt;

            // A consume counts even when a redirect flushes in the same cycle.
            if (w_consume) begin
                r_fetch_count <= r_fetch_count + CNT_W'(1);
            end

            if (w_req_fire) begin
                r_req_pc <= r_pc;
            end

            // Redirect wins over the sequential +4 advance.
            if (redirect_valid) begin
                r_pc <= w_redirect_pc;
            end else if (w_req_fire) begin
                r_pc <= r_pc + 32'd4;
            end

            // A response always retires the outstanding request (and any
            // pending discard). Otherwise a redirect with a request in flight,
            // or one being accepted now, marks that request stale.
            if (w_rsp_in_wait) begin
                r_discard <= 1'b0;
            end else if (redirect_valid && ((r_state == S_WAIT) || w_req_fire)) begin
                r_discard <= 1'b1;
            end

            if (redirect_valid) begin
                r_if_valid <= 1'b0;
            end else if (w_rsp_load) begin
                r_if_valid <= 1'b1;
                r_if_instr <= imem_rsp_data;
                r_if_pc    <= r_req_pc;
            end else if (w_consume) begin
                r_if_valid <= 1'b0;
            end
        end
    end

    assign imem_req_addr = r_pc;
    assign if_valid      = r_if_valid;
    assign if_instr      = r_if_instr;
    assign if_pc         = r_if_pc;
    assign fetch_count   = r_fetch_count;

endmodule

// File: tb/tb_fetch_pc_unit.sv
module tb_fetch_pc_unit;

    logic        clk;
    logic        reset;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        if_valid;
    logic        id_ready;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic [31:0] fetch_count;

    int checks = 0;
    int errors = 0;

    // Memory model state: response returned the cycle after acceptance.
    logic        auto_rsp;
    logic        pend;
    logic [31:0] pend_addr;
    logic        hs;
    logic [31:0] hs_addr;

    fetch_pc_unit dut (
        .clk            (clk),
        .reset          (reset),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .if_valid       (if_valid),
        .id_ready       (id_ready),
        .if_instr       (if_instr),
        .if_pc          (if_pc),
        .fetch_count    (fetch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: sample the request handshake mid-cycle, then after the edge
    // drive the memory response for whatever was accepted at that edge.
    task automatic tick();
        @(negedge clk);
        hs      = imem_req_valid && imem_req_ready && !reset;
        hs_addr = imem_req_addr;
        @(posedge clk);
        #1;
        if (hs) begin
            pend      = 1'b1;
            pend_addr = hs_addr;
        end
        if (auto_rsp && pend) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = pend_addr ^ 32'hDEAD_0000;
            pend           = 1'b0;
        end else begin
            imem_rsp_valid = 1'b0;
        end
        #1;
    endtask

    initial begin
        reset          = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'd0;
        id_ready       = 1'b1;
        auto_rsp       = 1'b1;
        pend           = 1'b0;
        pend_addr      = 32'd0;

        // ---- reset values
        tick();
        tick();
        check("rst_if_valid",  {31'd0, if_valid}, 32'd0);
        check("rst_if_instr",  if_instr, 32'd0);
        check("rst_if_pc",     if_pc, 32'd0);
        check("rst_count",     fetch_count, 32'd0);
        check("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
        check("rst_addr",      imem_req_addr, 32'h0000_3000);

        // ---- streaming with 1-cycle memory, ID always ready
        reset = 1'b0;
        #1;
        check("s1_req0_valid", {31'd0, imem_req_valid}, 32'd1);
        check("s1_req0_addr",  imem_req_addr, 32'h0000_3000);
        tick();
        check("s1_wait_noreq", {31'd0, imem_req_valid}, 32'd0);
        tick();
        check("s1_d0_valid", {31'd0, if_valid}, 32'd1);
        check("s1_d0_pc",    if_pc, 32'h0000_3000);
        check("s1_d0_instr", if_instr, 32'hDEAD_3000);
        check("s1_req1_addr", imem_req_addr, 32'h0000_3004);
        tick();
        check("s1_cnt1", fetch_count, 32'd1);
        tick();
        check("s1_d1_pc",    if_pc, 32'h0000_3004);
        check("s1_req2_addr", imem_req_addr, 32'h0000_3008);
        tick();
        tick();
        check("s1_d2_valid", {31'd0, if_valid}, 32'd1);
        check("s1_d2_pc",    if_pc, 32'h0000_3008);
        check("s1_req3_addr", imem_req_addr, 32'h0000_300C);

        // ---- redirect to 0x5002 coinciding with the 0x300C handshake
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_5002;
        tick();
        redirect_valid = 1'b0;
        #1;
        check("s4_flush_valid", {31'd0, if_valid}, 32'd0);
        check("s4_cnt3",        fetch_count, 32'd3);
        check("s4_wait_noreq",  {31'd0, imem_req_valid}, 32'd0);
        tick();
        check("s4_drop_valid", {31'd0, if_valid}, 32'd0);
        check("s4_req_valid",  {31'd0, imem_req_valid}, 32'd1);
        check("s4_req_addr",   imem_req_addr, 32'h0000_5000);
        tick();
        tick();
        check("s4_d_valid", {31'd0, if_valid}, 32'd1);
        check("s4_d_pc",    if_pc, 32'h0000_5000);
        check("s4_d_instr", if_instr, 32'hDEAD_5000);

        // ---- redirect (to the current pc) while buffer full and ID stalled
        id_ready       = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_5004;
        #1;
        check("s5_stall_noreq", {31'd0, imem_req_valid}, 32'd0);
        tick();
        redirect_valid = 1'b0;
        id_ready       = 1'b1;
        #1;
        check("s5_flush_valid", {31'd0, if_valid}, 32'd0);
        check("s5_cnt_same",    fetch_count, 32'd3);
        check("s5_req_valid",   {31'd0, imem_req_valid}, 32'd1);
        check("s5_req_addr",    imem_req_addr, 32'h0000_5004);

        // ---- reset again; ID stall after first delivery
        reset          = 1'b1;
        pend           = 1'b0;
        imem_rsp_valid = 1'b0;
        tick();
        tick();
        check("r2_count", fetch_count, 32'd0);
        reset = 1'b0;
        tick();
        tick();
        check("s2_d0_pc", if_pc, 32'h0000_3000);
        id_ready = 1'b0;
        #1;
        check("s2_stall_noreq", {31'd0, imem_req_valid}, 32'd0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("s2_hold_valid", {31'd0, if_valid}, 32'd1);
            check("s2_hold_pc",    if_pc, 32'h0000_3000);
            check("s2_hold_instr", if_instr, 32'hDEAD_3000);
            check("s2_hold_noreq", {31'd0, imem_req_valid}, 32'd0);
        end
        id_ready = 1'b1;
        #1;
        check("s2_resume_valid", {31'd0, imem_req_valid}, 32'd1);
        check("s2_resume_addr",  imem_req_addr, 32'h0000_3004);
        tick();
        check("s2_cnt1", fetch_count, 32'd1);
        tick();
        check("s2_d1_pc",     if_pc, 32'h0000_3004);
        check("s2_req2_addr", imem_req_addr, 32'h0000_3008);

        // ---- redirect to 0x4000 while waiting for 0x3008
        auto_rsp = 1'b0;
        tick();
        check("s3_cnt2", fetch_count, 32'd2);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_4000;
        tick();
        redirect_valid = 1'b0;
        check("s3_wait_noreq", {31'd0, imem_req_valid}, 32'd0);
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hDEAD_3008;
        pend           = 1'b0;
        auto_rsp       = 1'b1;
        tick();
        check("s3_drop_valid", {31'd0, if_valid}, 32'd0);
        check("s3_req_valid",  {31'd0, imem_req_valid}, 32'd1);
        check("s3_req_addr",   imem_req_addr, 32'h0000_4000);
        check("s3_cnt_same",   fetch_count, 32'd2);
        tick();
        tick();
        check("s3_d_valid", {31'd0, if_valid}, 32'd1);
        check("s3_d_pc",    if_pc, 32'h0000_4000);
        check("s3_d_instr", if_instr, 32'hDEAD_4000);

        // ---- reset while in S_WAIT with a pending discard
        auto_rsp = 1'b0;
        tick();
        check("s6_cnt3", fetch_count, 32'd3);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_6000;
        tick();
        redirect_valid = 1'b0;
        reset          = 1'b1;
        pend           = 1'b0;
        imem_rsp_valid = 1'b0;
        auto_rsp       = 1'b1;
        tick();
        check("s6_rst_count", fetch_count, 32'd0);
        check("s6_rst_valid", {31'd0, if_valid}, 32'd0);
        check("s6_rst_noreq", {31'd0, imem_req_valid}, 32'd0);
        check("s6_rst_addr",  imem_req_addr, 32'h0000_3000);
        reset = 1'b0;
        #1;
        check("s6_req_valid", {31'd0, imem_req_valid}, 32'd1);
        check("s6_req_addr",  imem_req_addr, 32'h0000_3000);
        tick();
        tick();
        check("s6_d_valid", {31'd0, if_valid}, 32'd1);
        check("s6_d_pc",    if_pc, 32'h0000_3000);
        check("s6_d_instr", if_instr, 32'hDEAD_3000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
